// File: rtl/sad_row_accumulator_if.sv
// sad_row_accumulator_if: row-sum input stream and block-SAD output stream
// of the SAD row accumulator, plus its status and best-candidate outputs.
// master = upstream/downstream environment, slave = the accumulator.
interface sad_row_accumulator_if #(
  parameter int ROW_W = 11,
  parameter int ROWS  = 8,
  parameter int SAD_W = ROW_W + $clog2(ROWS),
  parameter int IDX_W = 8
);
  logic [ROW_W-1:0] i_row_sum;
  logic             i_row_valid;
  logic             o_row_ready;
  logic [SAD_W-1:0] o_sad;
  logic             o_sad_valid;
  logic             i_sad_ready;
  logic             o_busy;
  logic [SAD_W-1:0] o_best_sad;
  logic [IDX_W-1:0] o_best_idx;

  modport master (
    output i_row_sum,
    output i_row_valid,
    input  o_row_ready,
    input  o_sad,
    input  o_sad_valid,
    output i_sad_ready,
    input  o_busy,
    input  o_best_sad,
    input  o_best_idx
  );

  modport slave (
    input  i_row_sum,
    input  i_row_valid,
    output o_row_ready,
    output o_sad,
    output o_sad_valid,
    input  i_sad_ready,
    output o_busy,
    output o_best_sad,
    output o_best_idx
  );
endinterface

// File: rtl/sad_row_accumulator.sv
// sad_row_accumulator: sums ROWS consecutive row SADs from the compressor
// array into one block SAD and offers it downstream with valid/ready.
// A new block may start in the same cycle the previous result is taken,
// so one row per cycle is sustained while the consumer is ready.
// Optional feature macro: BEST_SAD_TRACK_EN (running minimum block SAD and
// the index of the block that produced it).
module sad_row_accumulator #(
  parameter int ROW_W = 11,
  parameter int ROWS  = 8,
  parameter int SAD_W = ROW_W + $clog2(ROWS),
  parameter int IDX_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  sad_row_accumulator_if.slave bus
);

  localparam int              CNT_W    = $clog2(ROWS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [SAD_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SAD_W-1:0] sad_p1, sad_nxt;
  logic             vld_p1, vld_nxt;

  logic             row_ready;
  logic             row_acc;
  logic             blk_done;
  logic [SAD_W-1:0] row_ext;
  logic [SAD_W-1:0] blk_sum;

  // Row sums are unsigned; the block width covers ROWS full-scale rows.
  function automatic logic [SAD_W-1:0] zext_row(input logic [ROW_W-1:0] v);
    return SAD_W'(v);
  endfunction

  // Ready drops only while a result waits for the consumer, or on clear.
  assign row_ready = ~i_clear & ((state != HOLD) | bus.i_sad_ready);
  assign row_acc   = bus.i_row_valid & row_ready;
  assign row_ext   = zext_row(bus.i_row_sum);
  assign blk_sum   = acc + row_ext;
  assign blk_done  = row_acc & (state == ACCUM) & (cnt == LAST_CNT);

  // State, accumulator, row count and result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      sad_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      sad_p1 <= sad_nxt;
      vld_p1 <= vld_nxt;
    end
  end

  // Next-state and datapath update: clear first, then per-state behaviour.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    sad_nxt   = sad_p1;
    vld_nxt   = vld_p1;
    if (i_clear) begin
      // Abort: drop partial sum and any pending result; keep o_sad value.
      state_nxt = IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      vld_nxt   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (row_acc) begin
            acc_nxt   = row_ext;
            cnt_nxt   = CNT_W'(1);
            state_nxt = ACCUM;
          end
        end
        ACCUM: begin
          if (blk_done) begin
            sad_nxt   = blk_sum;
            vld_nxt   = 1'b1;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = HOLD;
          end else if (row_acc) begin
            acc_nxt = blk_sum;
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (bus.i_sad_ready) begin
            vld_nxt   = 1'b0;
            state_nxt = IDLE;
            // Back-to-back: the first row of the next block rides the handshake.
            if (row_acc) begin
              acc_nxt   = row_ext;
              cnt_nxt   = CNT_W'(1);
              state_nxt = ACCUM;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          vld_nxt   = 1'b0;
        end
      endcase
    end
  end

  assign bus.o_row_ready = row_ready;
  assign bus.o_sad       = sad_p1;
  assign bus.o_sad_valid = vld_p1;
  assign bus.o_busy      = (state != IDLE);

`ifdef BEST_SAD_TRACK_EN
  logic [SAD_W-1:0] best_sad;
  logic [IDX_W-1:0] best_idx;
  logic [IDX_W-1:0] cand_cnt;

  // Running minimum over completed blocks; strict compare keeps the earliest tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      best_sad <= '1;
      best_idx <= '0;
      cand_cnt <= '0;
    end else if (i_clear) begin
      best_sad <= '1;
      best_idx <= '0;
      cand_cnt <= '0;
    end else if (blk_done) begin
      cand_cnt <= cand_cnt + IDX_W'(1);
      if (blk_sum < best_sad) begin
        best_sad <= blk_sum;
        best_idx <= cand_cnt;
      end
    end
  end

  assign bus.o_best_sad = best_sad;
  assign bus.o_best_idx = best_idx;
`else
  assign bus.o_best_sad = SAD_W'(0);
  assign bus.o_best_idx = IDX_W'(0);
`endif

endmodule

// File: tb/tb_sad_row_accumulator.sv
// tb_sad_row_accumulator: directed scenarios followed by randomized traffic,
// all compared against a queue-based block-sum reference model.
module tb_sad_row_accumulator;

  localparam int ROW_W = 11;
  localparam int ROWS  = 8;
  localparam int SAD_W = 14;
  localparam int IDX_W = 8;
`ifdef BEST_SAD_TRACK_EN
  localparam bit BEST_ON = 1'b1;
`else
  localparam bit BEST_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic clear;

  sad_row_accumulator_if #(.ROW_W(ROW_W), .ROWS(ROWS), .SAD_W(SAD_W), .IDX_W(IDX_W)) bus ();

  sad_row_accumulator #(.ROW_W(ROW_W), .ROWS(ROWS), .SAD_W(SAD_W), .IDX_W(IDX_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clear (clear),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: accepted rows of the open block, pending result, best tracking.
  int m_rows[$];
  bit m_pend;
  int m_sad;
  int m_best;
  int m_idx;
  int m_cand;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rows.delete();
    m_pend = 1'b0;
    m_sad  = 0;
    m_best = (1 << SAD_W) - 1;
    m_idx  = 0;
    m_cand = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_sad_valid"}, int'(bus.o_sad_valid), int'(m_pend));
    check_eq({tag, "_sad"}, int'(bus.o_sad), m_sad);
    check_eq({tag, "_busy"}, int'(bus.o_busy), int'(m_pend || (m_rows.size() > 0)));
    check_eq({tag, "_best_sad"}, int'(bus.o_best_sad), BEST_ON ? m_best : 0);
    check_eq({tag, "_best_idx"}, int'(bus.o_best_idx), BEST_ON ? m_idx : 0);
  endtask

  // One clock cycle: drive at posedge+1, check ready before the edge,
  // advance the model, check registered outputs at next posedge+1.
  task automatic step(input bit v, input int r, input bit sr, input bit clr);
    bit exp_ready;
    bit accepted;
    int s;
    bus.i_row_valid = v;
    bus.i_row_sum   = ROW_W'(r);
    bus.i_sad_ready = sr;
    clear           = clr;
    #3;
    exp_ready = !clr && (!m_pend || sr);
    check_eq("row_ready", int'(bus.o_row_ready), int'(exp_ready));
    accepted = v && exp_ready;
    if (clr) begin
      m_rows.delete();
      m_pend = 1'b0;
      m_best = (1 << SAD_W) - 1;
      m_idx  = 0;
      m_cand = 0;
    end else begin
      if (m_pend && sr) m_pend = 1'b0;
      if (accepted) begin
        m_rows.push_back(r);
        if (m_rows.size() == ROWS) begin
          s = 0;
          foreach (m_rows[k]) s += m_rows[k];
          m_sad  = s;
          m_pend = 1'b1;
          if (s < m_best) begin
            m_best = s;
            m_idx  = m_cand;
          end
          m_cand = (m_cand + 1) % (1 << IDX_W);
          m_rows.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic send_block_first(input int first);
    step(1'b1, first, 1'b1, 1'b0);
    for (int i = 1; i < ROWS; i++) step(1'b1, 0, 1'b1, 1'b0);
  endtask

  int held_sad;

  initial begin
    rst_n           = 1'b0;
    clear           = 1'b0;
    bus.i_row_valid = 1'b0;
    bus.i_row_sum   = '0;
    bus.i_sad_ready = 1'b0;
    model_reset();
    #3;
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Scenario 1: eight full-scale rows back to back.
    for (int i = 0; i < ROWS; i++) step(1'b1, 2040, 1'b1, 1'b0);
    check_eq("t1_sad_const", int'(bus.o_sad), 16320);
    check_eq("t1_valid_after_row8", int'(bus.o_sad_valid), 1);
    step(1'b0, 0, 1'b1, 1'b0);
    check_eq("t1_valid_one_cycle", int'(bus.o_sad_valid), 0);

    // Scenario 2: rows 1..8 with idle gaps.
    for (int i = 1; i <= ROWS; i++) begin
      step(1'b1, i, 1'b1, 1'b0);
      idle_cycles(i % 3);
    end
    check_eq("t2_sad_const", int'(bus.o_sad), 36);

    // Scenario 3: consumer stalls 5 cycles, then handshake with a new row.
    idle_cycles(1);
    for (int i = 0; i < ROWS; i++) step(1'b1, 100 + i, 1'b0, 1'b0);
    held_sad = int'(bus.o_sad);
    check_eq("t3_sad_const", held_sad, 828);
    for (int i = 0; i < 5; i++) step(1'b1, 7, 1'b0, 1'b0);
    check_eq("t3_sad_stable", int'(bus.o_sad), held_sad);
    check_eq("t3_valid_held", int'(bus.o_sad_valid), 1);
    step(1'b1, 9, 1'b1, 1'b0);
    check_eq("t3_busy_next_block", int'(bus.o_busy), 1);
    for (int i = 1; i < ROWS; i++) step(1'b1, 1, 1'b1, 1'b0);
    check_eq("t3_next_block_sad", int'(bus.o_sad), 16);
    idle_cycles(1);

    // Scenario 4: clear after three rows aborts the block.
    for (int i = 0; i < 3; i++) step(1'b1, 10, 1'b1, 1'b0);
    step(1'b1, 10, 1'b1, 1'b1);
    check_eq("t4_busy_after_clear", int'(bus.o_busy), 0);
    for (int i = 0; i < ROWS; i++) step(1'b1, 5, 1'b1, 1'b0);
    check_eq("t4_sad_const", int'(bus.o_sad), 40);
    idle_cycles(1);

    // Scenario 5: asynchronous reset in the middle of a block.
    for (int i = 0; i < 3; i++) step(1'b1, 33, 1'b1, 1'b0);
    bus.i_row_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("t5_busy_async", int'(bus.o_busy), 0);
    check_eq("t5_sad_async", int'(bus.o_sad), 0);
    check_eq("t5_valid_async", int'(bus.o_sad_valid), 0);
    check_eq("t5_best_async", int'(bus.o_best_sad), BEST_ON ? ((1 << SAD_W) - 1) : 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.i_row_valid = 1'b0;
    idle_cycles(2);

    // Scenario 6: best-SAD tracking over 100, 50, 50, 70.
    step(1'b0, 0, 1'b1, 1'b1);
    send_block_first(100);
    send_block_first(50);
    send_block_first(50);
    send_block_first(70);
    check_eq("t6_best_sad", int'(bus.o_best_sad), BEST_ON ? 50 : 0);
    check_eq("t6_best_idx", int'(bus.o_best_idx), BEST_ON ? 1 : 0);
    idle_cycles(1);

    // Randomized traffic: bursts, gaps, back-pressure and occasional clears.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) < 75,
           int'($urandom_range((1 << ROW_W) - 1)),
           $urandom_range(99) < 60,
           $urandom_range(199) < 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
